// File: rtl/stream_compare_pkg.sv
// Shared types and helpers for the multi-width stream comparator.
// Holds the FSM state encoding, per-pop count deltas and the popcount / saturating-add functions.
package stream_compare_pkg;

    localparam int CNT_WIDTH_DEF = 32;
    localparam int MAX_TDATA_W   = 512;
    localparam int MAX_CNT_W     = 64;
    localparam int POP_W         = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } state_t;

    // Amount each live counter advances on one pop (word/err are 0 or 1).
    typedef struct packed {
        logic [POP_W-1:0] word;
        logic [POP_W-1:0] err;
        logic [POP_W-1:0] bit_err;
    } status_t;

    function automatic logic [POP_W-1:0] popcount(input logic [MAX_TDATA_W-1:0] v);
        logic [POP_W-1:0] n;
        n = '0;
        for (int i = 0; i < MAX_TDATA_W; i++) begin
            n = n + POP_W'(v[i]);
        end
        return n;
    endfunction

    // a is never above max_v, so the guard below cannot underflow.
    function automatic logic [MAX_CNT_W-1:0] sat_add(input logic [MAX_CNT_W-1:0] a,
                                                     input logic [MAX_CNT_W-1:0] b,
                                                     input logic [MAX_CNT_W-1:0] max_v);
        if (b > (max_v - a)) begin
            return max_v;
        end else begin
            return a + b;
        end
    endfunction

endpackage

// File: rtl/stream_compare_fifo.sv
// Per-side synchronous FIFO with synchronous flush; read data is the head word, valid while not empty.
module stream_compare_fifo
    import stream_compare_pkg::*;
#(
    parameter int W  = 32,
    parameter int AW = 3
) (
    input  logic         clk,
    input  logic         aresetn,
    input  logic         i_flush,
    input  logic         i_wr_en,
    input  logic [W-1:0] i_wr_data,
    input  logic         i_rd_en,
    output logic [W-1:0] o_rd_data,
    output logic         o_full,
    output logic         o_empty
);

    localparam int DEPTH = 1 << AW;

    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wr_ptr;
    logic [AW:0]  r_rd_ptr;
    logic         w_do_wr;
    logic         w_do_rd;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_wr   = i_wr_en && !o_full && !i_flush;
    assign w_do_rd   = i_rd_en && !o_empty && !i_flush;
    assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];

    // Pointer update; flush empties the FIFO regardless of same-cycle traffic.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_wr) r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
            if (w_do_rd) r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (w_do_wr) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
    end

endmodule

// File: rtl/stream_compare_multi.sv
// Word-by-word comparator of two AXI-Stream inputs with skew FIFOs, masked compare,
// saturating word/error/bit-error counters, first-error capture and a latched snapshot.
module stream_compare_multi
    import stream_compare_pkg::*;
#(
    parameter int TDATA_WIDTH = 32,
    parameter int FIFO_AW     = 3,
    parameter int CNT_WIDTH   = CNT_WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   aresetn,
    input  logic [TDATA_WIDTH-1:0] S_AXIS_0_TDATA,
    input  logic                   S_AXIS_0_TVALID,
    output logic                   S_AXIS_0_TREADY,
    input  logic [TDATA_WIDTH-1:0] S_AXIS_1_TDATA,
    input  logic                   S_AXIS_1_TVALID,
    output logic                   S_AXIS_1_TREADY,
    input  logic                   ctrl_enable,
    input  logic                   ctrl_clear,
    input  logic                   ctrl_stop_on_err,
    input  logic                   ctrl_latch,
    input  logic [TDATA_WIDTH-1:0] cmp_mask,
    output logic [CNT_WIDTH-1:0]   snap_word_count,
    output logic [CNT_WIDTH-1:0]   snap_err_count,
    output logic [CNT_WIDTH-1:0]   snap_bit_err_count,
    output logic                   first_err_valid,
    output logic [CNT_WIDTH-1:0]   first_err_index,
    output logic [TDATA_WIDTH-1:0] first_err_xor,
    output logic                   skew_fault,
    output logic [1:0]             state
);

    localparam logic [MAX_CNT_W-1:0] CNT_MAX = MAX_CNT_W'({CNT_WIDTH{1'b1}});

    state_t                 r_state;
    logic                   r_rst_done;
    logic [CNT_WIDTH-1:0]   r_word, r_err, r_bit_err;
    logic [CNT_WIDTH-1:0]   r_snap_word, r_snap_err, r_snap_bit_err;
    logic                   r_fe_valid;
    logic [CNT_WIDTH-1:0]   r_fe_index;
    logic [TDATA_WIDTH-1:0] r_fe_xor;
    logic                   r_skew;

    logic                   w_full0, w_full1, w_empty0, w_empty1;
    logic [TDATA_WIDTH-1:0] w_rd0, w_rd1;
    logic                   w_tready0, w_tready1;
    logic                   w_run, w_flush, w_wr0, w_wr1, w_pop, w_mism, w_skew;
    logic [TDATA_WIDTH-1:0] w_diff;
    status_t                w_delta;
    logic [CNT_WIDTH-1:0]   w_word_nxt, w_err_nxt, w_bit_err_nxt;

    assign w_run   = (r_state == ST_RUN);
    assign w_flush = ctrl_clear || (r_state == ST_IDLE);
    assign w_wr0   = w_run && S_AXIS_0_TVALID && w_tready0;
    assign w_wr1   = w_run && S_AXIS_1_TVALID && w_tready1;
    assign w_pop   = w_run && !w_empty0 && !w_empty1 && !ctrl_clear;
    assign w_diff  = (w_rd0 ^ w_rd1) & cmp_mask;
    assign w_mism  = w_pop && (w_diff != '0);
    assign w_skew  = w_run && ((w_full0 && w_empty1) || (w_full1 && w_empty0));

    stream_compare_fifo #(.W(TDATA_WIDTH), .AW(FIFO_AW)) u_fifo0 (
        .clk       (clk),
        .aresetn   (aresetn),
        .i_flush   (w_flush),
        .i_wr_en   (w_wr0),
        .i_wr_data (S_AXIS_0_TDATA),
        .i_rd_en   (w_pop),
        .o_rd_data (w_rd0),
        .o_full    (w_full0),
        .o_empty   (w_empty0)
    );

    stream_compare_fifo #(.W(TDATA_WIDTH), .AW(FIFO_AW)) u_fifo1 (
        .clk       (clk),
        .aresetn   (aresetn),
        .i_flush   (w_flush),
        .i_wr_en   (w_wr1),
        .i_wr_data (S_AXIS_1_TDATA),
        .i_rd_en   (w_pop),
        .o_rd_data (w_rd1),
        .o_full    (w_full1),
        .o_empty   (w_empty1)
    );

    // Ready per state: IDLE sinks everything, RUN backpressures on full, HALT and reset stall.
    always_comb begin
        w_tready0 = 1'b0;
        w_tready1 = 1'b0;
        if (r_rst_done) begin
            case (r_state)
                ST_IDLE: begin
                    w_tready0 = 1'b1;
                    w_tready1 = 1'b1;
                end
                ST_RUN: begin
                    w_tready0 = !w_full0;
                    w_tready1 = !w_full1;
                end
                default: begin
                    w_tready0 = 1'b0;
                    w_tready1 = 1'b0;
                end
            endcase
        end else begin
            w_tready0 = 1'b0;
            w_tready1 = 1'b0;
        end
    end

    // Counter deltas for the current pop.
    always_comb begin
        w_delta = '0;
        if (w_pop) begin
            w_delta.word = POP_W'(1'b1);
            if (w_diff != '0) begin
                w_delta.err     = POP_W'(1'b1);
                w_delta.bit_err = popcount(MAX_TDATA_W'(w_diff));
            end else begin
                w_delta.err     = '0;
                w_delta.bit_err = '0;
            end
        end else begin
            w_delta = '0;
        end
    end

    assign w_word_nxt    = CNT_WIDTH'(sat_add(MAX_CNT_W'(r_word),    MAX_CNT_W'(w_delta.word),    CNT_MAX));
    assign w_err_nxt     = CNT_WIDTH'(sat_add(MAX_CNT_W'(r_err),     MAX_CNT_W'(w_delta.err),     CNT_MAX));
    assign w_bit_err_nxt = CNT_WIDTH'(sat_add(MAX_CNT_W'(r_bit_err), MAX_CNT_W'(w_delta.bit_err), CNT_MAX));

    // Holds ready low for the first cycle out of reset.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) r_rst_done <= 1'b0;
        else          r_rst_done <= 1'b1;
    end

    // Control FSM; clear overrides every transition.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= ST_IDLE;
        end else if (ctrl_clear) begin
            r_state <= ctrl_enable ? ST_RUN : ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: r_state <= ctrl_enable ? ST_RUN : ST_IDLE;
                ST_RUN: begin
                    if (!ctrl_enable)                      r_state <= ST_IDLE;
                    else if (w_mism && ctrl_stop_on_err)   r_state <= ST_HALT;
                    else                                   r_state <= ST_RUN;
                end
                ST_HALT: r_state <= ctrl_enable ? ST_HALT : ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Live counters, snapshot, first-error capture and sticky skew flag.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_word         <= '0;
            r_err          <= '0;
            r_bit_err      <= '0;
            r_snap_word    <= '0;
            r_snap_err     <= '0;
            r_snap_bit_err <= '0;
            r_fe_valid     <= 1'b0;
            r_fe_index     <= '0;
            r_fe_xor       <= '0;
            r_skew         <= 1'b0;
        end else if (ctrl_clear) begin
            r_word         <= '0;
            r_err          <= '0;
            r_bit_err      <= '0;
            r_snap_word    <= '0;
            r_snap_err     <= '0;
            r_snap_bit_err <= '0;
            r_fe_valid     <= 1'b0;
            r_fe_index     <= '0;
            r_fe_xor       <= '0;
            r_skew         <= 1'b0;
        end else begin
            r_word    <= w_word_nxt;
            r_err     <= w_err_nxt;
            r_bit_err <= w_bit_err_nxt;
            if (ctrl_latch) begin
                r_snap_word    <= r_word;
                r_snap_err     <= r_err;
                r_snap_bit_err <= r_bit_err;
            end
            if (w_mism && !r_fe_valid) begin
                r_fe_valid <= 1'b1;
                r_fe_index <= r_word;
                r_fe_xor   <= w_diff;
            end
            if (w_skew) r_skew <= 1'b1;
        end
    end

    assign S_AXIS_0_TREADY    = w_tready0;
    assign S_AXIS_1_TREADY    = w_tready1;
    assign snap_word_count    = r_snap_word;
    assign snap_err_count     = r_snap_err;
    assign snap_bit_err_count = r_snap_bit_err;
    assign first_err_valid    = r_fe_valid;
    assign first_err_index    = r_fe_index;
    assign first_err_xor      = r_fe_xor;
    assign skew_fault         = r_skew;
    assign state              = r_state;

endmodule

// File: tb/tb_stream_compare_multi.sv
// Directed bench for stream_compare_multi; counters are 8 bits wide so saturation is reachable.
module tb_stream_compare_multi;

    logic        clk;
    logic        aresetn;
    logic [31:0] s0_data, s1_data;
    logic        s0_valid, s1_valid, s0_ready, s1_ready;
    logic        ctrl_enable, ctrl_clear, ctrl_stop_on_err, ctrl_latch;
    logic [31:0] cmp_mask;
    logic [7:0]  snap_word, snap_err, snap_bit;
    logic        fe_valid;
    logic [7:0]  fe_index;
    logic [31:0] fe_xor;
    logic        skew;
    logic [1:0]  st;

    int n_tests = 0;
    int n_fail  = 0;
    int acc;

    stream_compare_multi #(.TDATA_WIDTH(32), .FIFO_AW(3), .CNT_WIDTH(8)) dut (
        .clk                (clk),
        .aresetn            (aresetn),
        .S_AXIS_0_TDATA     (s0_data),
        .S_AXIS_0_TVALID    (s0_valid),
        .S_AXIS_0_TREADY    (s0_ready),
        .S_AXIS_1_TDATA     (s1_data),
        .S_AXIS_1_TVALID    (s1_valid),
        .S_AXIS_1_TREADY    (s1_ready),
        .ctrl_enable        (ctrl_enable),
        .ctrl_clear         (ctrl_clear),
        .ctrl_stop_on_err   (ctrl_stop_on_err),
        .ctrl_latch         (ctrl_latch),
        .cmp_mask           (cmp_mask),
        .snap_word_count    (snap_word),
        .snap_err_count     (snap_err),
        .snap_bit_err_count (snap_bit),
        .first_err_valid    (fe_valid),
        .first_err_index    (fe_index),
        .first_err_xor      (fe_xor),
        .skew_fault         (skew),
        .state              (st)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic start_run();
        @(negedge clk);
        ctrl_clear  = 1'b1;
        ctrl_enable = 1'b1;
        @(negedge clk);
        ctrl_clear  = 1'b0;
    endtask

    task automatic do_latch();
        @(negedge clk);
        ctrl_latch = 1'b1;
        @(negedge clk);
        ctrl_latch = 1'b0;
    endtask

    // Side 1 starts dly cycles late; word err_idx (or every word) of side 1 is XORed with err_pat.
    task automatic send_ramps(input int n, input int dly, input int err_idx, input logic [31:0] err_pat,
                              input bit all_err, input int budget, output int acc0);
        int i0, i1, cyc;
        i0 = 0; i1 = 0; cyc = 0;
        while ((i0 < n || i1 < n) && cyc < budget) begin
            @(negedge clk);
            s0_valid = (i0 < n);
            s0_data  = 32'h0000_1000 + 32'(i0);
            s1_valid = (i1 < n) && (cyc >= dly);
            s1_data  = 32'h0000_1000 + 32'(i1);
            if (all_err || i1 == err_idx) s1_data = s1_data ^ err_pat;
            if (s0_valid && s0_ready) i0++;
            if (s1_valid && s1_ready) i1++;
            cyc++;
        end
        @(negedge clk);
        s0_valid = 1'b0;
        s1_valid = 1'b0;
        acc0 = i0;
    endtask

    initial begin
        clk = 1'b0; aresetn = 1'b0;
        s0_data = 32'h0; s1_data = 32'h0; s0_valid = 1'b0; s1_valid = 1'b0;
        ctrl_enable = 1'b0; ctrl_clear = 1'b0; ctrl_stop_on_err = 1'b0; ctrl_latch = 1'b0;
        cmp_mask = 32'hFFFF_FFFF;
        repeat (2) @(negedge clk);
        check_val("rst_state",   64'(st),       64'd0);
        check_val("rst_tready0", 64'(s0_ready), 64'd0);
        check_val("rst_tready1", 64'(s1_ready), 64'd0);
        check_val("rst_snap",    64'(snap_word), 64'd0);
        aresetn = 1'b1;
        repeat (2) @(negedge clk);
        check_val("idle_tready0", 64'(s0_ready), 64'd1);
        check_val("idle_tready1", 64'(s1_ready), 64'd1);

        // Clean ramps, side 1 five cycles late
        start_run();
        send_ramps(100, 5, -1, 32'h0, 1'b0, 300, acc);
        repeat (4) @(negedge clk);
        do_latch();
        check_val("t1_acc",   64'(acc),       64'd100);
        check_val("t1_word",  64'(snap_word), 64'd100);
        check_val("t1_err",   64'(snap_err),  64'd0);
        check_val("t1_bit",   64'(snap_bit),  64'd0);
        check_val("t1_skew",  64'(skew),      64'd0);
        check_val("t1_fev",   64'(fe_valid),  64'd0);

        // Word 17 of side 1 has bits 0 and 4 flipped
        start_run();
        check_val("t2_clr_snap", 64'(snap_word), 64'd0);
        send_ramps(100, 5, 17, 32'h0000_0011, 1'b0, 300, acc);
        repeat (4) @(negedge clk);
        do_latch();
        check_val("t2_word", 64'(snap_word), 64'd100);
        check_val("t2_err",  64'(snap_err),  64'd1);
        check_val("t2_bit",  64'(snap_bit),  64'd2);
        check_val("t2_fev",  64'(fe_valid),  64'd1);
        check_val("t2_fei",  64'(fe_index),  64'd17);
        check_val("t2_fex",  64'(fe_xor),    64'h11);

        // Flipped bits masked out
        cmp_mask = 32'hFFFF_FFEE;
        start_run();
        send_ramps(100, 5, 17, 32'h0000_0011, 1'b0, 300, acc);
        repeat (4) @(negedge clk);
        do_latch();
        check_val("t3_word", 64'(snap_word), 64'd100);
        check_val("t3_err",  64'(snap_err),  64'd0);
        check_val("t3_bit",  64'(snap_bit),  64'd0);
        check_val("t3_fev",  64'(fe_valid),  64'd0);

        // All-zero mask: every word differs but nothing counts as an error
        cmp_mask = 32'h0;
        start_run();
        send_ramps(5, 0, -1, 32'hFFFF_FFFF, 1'b1, 50, acc);
        repeat (4) @(negedge clk);
        do_latch();
        check_val("t3b_word", 64'(snap_word), 64'd5);
        check_val("t3b_err",  64'(snap_err),  64'd0);
        check_val("t3b_fev",  64'(fe_valid),  64'd0);
        cmp_mask = 32'hFFFF_FFFF;

        // Stop on error at word 3
        ctrl_stop_on_err = 1'b1;
        start_run();
        send_ramps(10, 0, 3, 32'h0000_0001, 1'b0, 40, acc);
        do_latch();
        check_val("t4_state",   64'(st),        64'd2);
        check_val("t4_word",    64'(snap_word), 64'd4);
        check_val("t4_err",     64'(snap_err),  64'd1);
        check_val("t4_tready0", 64'(s0_ready),  64'd0);
        check_val("t4_tready1", 64'(s1_ready),  64'd0);
        ctrl_enable = 1'b0;
        @(negedge clk);
        check_val("t4_idle", 64'(st), 64'd0);
        ctrl_stop_on_err = 1'b0;

        // Side 1 silent: side 0 stalls after 8 words
        start_run();
        send_ramps(10, 1000, -1, 32'h0, 1'b0, 40, acc);
        check_val("t5_acc",    64'(acc),      64'd8);
        check_val("t5_tready", 64'(s0_ready), 64'd0);
        check_val("t5_skew",   64'(skew),     64'd1);
        do_latch();
        check_val("t5_word",   64'(snap_word), 64'd0);

        // Latch in the same cycle as a pop captures the pre-increment count
        start_run();
        @(negedge clk);
        s0_valid = 1'b1; s1_valid = 1'b1; s0_data = 32'h55; s1_data = 32'h55;
        @(negedge clk);
        s0_valid = 1'b0; s1_valid = 1'b0; ctrl_latch = 1'b1;
        @(negedge clk);
        ctrl_latch = 1'b0;
        check_val("t6_latch_pre",  64'(snap_word), 64'd0);
        do_latch();
        check_val("t6_latch_post", 64'(snap_word), 64'd1);

        // Saturation: 260 fully mismatched words into 8-bit counters
        start_run();
        send_ramps(260, 0, -1, 32'hFFFF_FFFF, 1'b1, 400, acc);
        repeat (4) @(negedge clk);
        do_latch();
        check_val("t7_acc",  64'(acc),       64'd260);
        check_val("t7_word", 64'(snap_word), 64'hFF);
        check_val("t7_err",  64'(snap_err),  64'hFF);
        check_val("t7_bit",  64'(snap_bit),  64'hFF);
        check_val("t7_fei",  64'(fe_index),  64'd0);
        check_val("t7_fex",  64'(fe_xor),    64'hFFFF_FFFF);

        // Asynchronous reset mid-stream
        @(negedge clk);
        s0_valid = 1'b1; s1_valid = 1'b1; s0_data = 32'h1; s1_data = 32'h2;
        @(negedge clk);
        aresetn = 1'b0;
        #1;
        check_val("t8_state",   64'(st),        64'd0);
        check_val("t8_tready0", 64'(s0_ready),  64'd0);
        check_val("t8_tready1", 64'(s1_ready),  64'd0);
        check_val("t8_word",    64'(snap_word), 64'd0);
        check_val("t8_err",     64'(snap_err),  64'd0);
        check_val("t8_bit",     64'(snap_bit),  64'd0);
        check_val("t8_fev",     64'(fe_valid),  64'd0);
        check_val("t8_fei",     64'(fe_index),  64'd0);
        check_val("t8_fex",     64'(fe_xor),    64'd0);
        check_val("t8_skew",    64'(skew),      64'd0);
        @(negedge clk);
        s0_valid = 1'b0; s1_valid = 1'b0; ctrl_enable = 1'b0;
        aresetn = 1'b1;
        repeat (2) @(negedge clk);
        check_val("t8_post_state",  64'(st),       64'd0);
        check_val("t8_post_tready", 64'(s0_ready), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/stream_compare_multi.md
Name: stream_compare_multi

Overview:
- Parametrised successor to the team's two-stream comparator.
- Compares two AXI-Stream inputs of generic width word-by-word. Per-side elastic FIFOs absorb skew, so both sides no longer have to be valid in the same cycle.
- Adds a bit-compare mask, bit-error counting, first-error capture, saturating counters, a stop-on-error mode and a latched status snapshot.
- Sits between two data sources under test (e.g. link loopback vs. reference generator) and a register wrapper on the IPIF bus.

Parameters:
- TDATA_WIDTH, 32, stream data width in bits (1..512).
- FIFO_AW, 3, log2 of per-side FIFO depth; depth = 2^FIFO_AW = max tolerated skew in words.
- CNT_WIDTH, 32, width of all counters.

Ports:
- clk  in  1  single clock for all logic.
- aresetn  in  1  asynchronous active-low reset.
- S_AXIS_0_TDATA  in  TDATA_WIDTH  side-0 data.
- S_AXIS_0_TVALID  in  1  side-0 valid.
- S_AXIS_0_TREADY  out  1  side-0 ready.
- S_AXIS_1_TDATA  in  TDATA_WIDTH  side-1 data.
- S_AXIS_1_TVALID  in  1  side-1 valid.
- S_AXIS_1_TREADY  out  1  side-1 ready.
- ctrl_enable  in  1  level; 1 = compare, 0 = idle/drain.
- ctrl_clear  in  1  synchronous pulse; clears counters, flags and FIFOs.
- ctrl_stop_on_err  in  1  level; halt on first mismatch.
- ctrl_latch  in  1  pulse; copy live counters into the snapshot outputs.
- cmp_mask  in  TDATA_WIDTH  1 = bit participates in the compare.
- snap_word_count  out  CNT_WIDTH  latched compared-word count.
- snap_err_count  out  CNT_WIDTH  latched mismatched-word count.
- snap_bit_err_count  out  CNT_WIDTH  latched mismatched-bit count.
- first_err_valid  out  1  sticky; a mismatch has been captured.
- first_err_index  out  CNT_WIDTH  word index (0-based) of the first mismatch.
- first_err_xor  out  TDATA_WIDTH  masked XOR pattern of the first mismatch.
- skew_fault  out  1  sticky; one FIFO was full while the other was empty.
- state  out  2  00 IDLE, 01 RUN, 10 HALT.

Behaviour:
- Reset (aresetn=0, asynchronous): all counters, snapshots, first_err_* and skew_fault = 0; FIFOs empty; state = IDLE; both TREADY = 0 while reset is asserted.
- IDLE:
  - both TREADY = 1; accepted words are discarded; FIFOs are flushed; counters hold.
  - ctrl_enable=1 -> RUN on the next edge.
- RUN:
  - TREADY_n = !fifo_n_full; a beat is written on TVALID & TREADY.
  - Pop both FIFOs in the same cycle when both are non-empty.
  - diff = (d0 ^ d1) & cmp_mask.
  - At the pop edge: word_count += 1; if diff != 0, err_count += 1 and bit_err_count += popcount(diff).
  - Latency: a word accepted on both sides at edge N is counted at edge N+1.
- HALT:
  - Entered at the pop edge of a mismatch when ctrl_stop_on_err=1. That mismatch is counted.
  - Both TREADY = 0; no pops; counters frozen.
  - ctrl_enable=0 -> IDLE. ctrl_clear is the only other exit.
- RUN with ctrl_enable=0 -> IDLE on the next edge; FIFO contents are dropped.
- First error: on the first mismatch with first_err_valid=0, capture first_err_index = word_count before the increment and first_err_xor = diff, then set first_err_valid.
- Saturation: every counter holds at all-ones and never wraps. bit_err_count saturates if the addition would overflow.
- skew_fault: set in any cycle where one FIFO is full and the other is empty in RUN. It is sticky until clear or reset.
- ctrl_clear has highest priority:
  - zeroes counters, snapshots, first_err_*, skew_fault; flushes FIFOs.
  - next state = RUN if ctrl_enable else IDLE.
  - A pop in the clear cycle is discarded.
- ctrl_latch: snapshots take the live counter values before any same-cycle increment. Latch and clear in the same cycle gives snapshots = 0.
- cmp_mask is sampled combinationally at the pop. An all-zero mask means no errors are ever counted.

Decomposition:
- Package stream_compare_pkg: state enum (IDLE/RUN/HALT), CNT_WIDTH default, and a status struct {word, err, bit_err counts}.
- Sub-module stream_compare_fifo: synchronous FIFO of depth 2^FIFO_AW with flush, full and empty outputs. Instantiated once per side.
- Popcount and saturating-add are functions in the package.

Test Plan:
- Identical ramps on both sides, 100 words, side 1 delayed 5 cycles, FIFO_AW=3 -> word=100, err=0, bit_err=0, skew_fault=0.
- Ramps where word 17 of side 1 has bits 0 and 4 flipped -> err=1, bit_err=2, first_err_index=17, first_err_xor=0x11.
- Same as the previous case with cmp_mask=0xFFFFFFEE -> err=0, bit_err=0, first_err_valid=0.
- ctrl_stop_on_err=1, mismatch at word 3 -> state=HALT, word=4, err=1, both TREADY=0; ctrl_enable=0 -> IDLE.
- Side 1 silent while side 0 sends 10 words -> S_AXIS_0_TREADY falls after 8 accepted, skew_fault=1, word=0.
- Force word_count to all-ones, send 1 more word -> stays 0xFFFFFFFF. ctrl_latch together with a pop -> snapshot holds the pre-increment value. Pulse aresetn low mid-stream -> all outputs 0, state=IDLE.
